// File: rtl/trees_pkg.sv
// Shared types and sizing constants for the tree-ensemble feeder.
// The sizing constants describe the default ensemble geometry.
package trees_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_TREES,
      LOAD_FEAT,
      START,
      WAIT,
      OUTPUT,
      FINISH
   } feeder_st_t;

   localparam int DEF_N_TREES          = 16;
   localparam int DEF_N_NODE_AND_LEAFS = 256;
   localparam int DEF_N_FEATURE        = 32;

   localparam int TREE_WORDS = DEF_N_TREES * DEF_N_NODE_AND_LEAFS;
   localparam int FEAT_WORDS = DEF_N_FEATURE / 2;

endpackage

// File: rtl/trees_feeder.sv
// Streams tree images and feature pairs into the ensemble, runs one inference per sample, forwards predictions.
// Load strobes, start and acc_done are registered (one cycle after the causing event); out_valid holds until out_ready.
module trees_feeder
   import trees_pkg::*;
#(
   parameter int  N_TREES          = DEF_N_TREES,
   parameter int  N_NODE_AND_LEAFS = DEF_N_NODE_AND_LEAFS,
   parameter int  N_FEATURE        = DEF_N_FEATURE,
   localparam int TW               = $clog2(N_TREES),
   localparam int NW               = $clog2(N_NODE_AND_LEAFS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_start,
   input  logic          cfg_load_trees,
   input  logic [31:0]   cfg_n_samples,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [63:0]   in_data,
   output logic          load_trees,
   output logic [NW-1:0] n_node,
   output logic [TW-1:0] n_tree,
   output logic [63:0]   tree_nodes,
   output logic          load_features,
   output logic [31:0]   n_feature,
   output logic [63:0]   features2,
   output logic          start,
   input  logic [31:0]   prediction,
   input  logic          done,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_data,
   output logic          busy,
   output logic          acc_done
);

   feeder_st_t    state, state_nxt;
   logic [31:0]   n_samples, sample_cnt, feat_cnt;
   logic [TW-1:0] tree_cnt;
   logic [NW-1:0] node_cnt;
   logic          in_hs, out_hs, done_ok, last_node, last_tree_word, last_feat_word, last_sample;

   assign in_hs          = in_valid & in_ready;
   assign out_hs         = out_valid & out_ready;
   // the ensemble may still flag done from the previous run while start is high
   assign done_ok        = done & ~start;
   assign last_node      = (node_cnt == NW'(N_NODE_AND_LEAFS - 1));
   assign last_tree_word = last_node && (tree_cnt == TW'(N_TREES - 1));
   assign last_feat_word = (feat_cnt == 32'(N_FEATURE - 2));
   assign last_sample    = ((sample_cnt + 32'd1) == n_samples);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cfg_start) begin
               if (cfg_load_trees)            state_nxt = LOAD_TREES;
               else if (cfg_n_samples == '0)  state_nxt = FINISH;
               else                           state_nxt = LOAD_FEAT;
            end
         end
         LOAD_TREES: if (in_hs && last_tree_word) state_nxt = (n_samples == '0) ? FINISH : LOAD_FEAT;
         LOAD_FEAT:  if (in_hs && last_feat_word) state_nxt = START;
         START:      state_nxt = WAIT;
         WAIT:       if (done_ok) state_nxt = OUTPUT;
         OUTPUT:     if (out_hs) state_nxt = last_sample ? FINISH : LOAD_FEAT;
         FINISH:     state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      if (state == LOAD_TREES || state == LOAD_FEAT) in_ready = 1'b1;
      if (state != IDLE)                             busy     = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_samples     <= '0;
         sample_cnt    <= '0;
         feat_cnt      <= '0;
         tree_cnt      <= '0;
         node_cnt      <= '0;
         load_trees    <= 1'b0;
         n_node        <= '0;
         n_tree        <= '0;
         tree_nodes    <= '0;
         load_features <= 1'b0;
         n_feature     <= '0;
         features2     <= '0;
         start         <= 1'b0;
         out_valid     <= 1'b0;
         out_data      <= '0;
         acc_done      <= 1'b0;
      end else begin
         load_trees    <= 1'b0;
         load_features <= 1'b0;
         start         <= (state == START);
         acc_done      <= (state == FINISH);
         case (state)
            IDLE: begin
               if (cfg_start) begin
                  n_samples  <= cfg_n_samples;
                  sample_cnt <= '0;
                  feat_cnt   <= '0;
                  tree_cnt   <= '0;
                  node_cnt   <= '0;
               end
            end
            LOAD_TREES: begin
               if (in_hs) begin
                  load_trees <= 1'b1;
                  tree_nodes <= in_data;
                  n_tree     <= tree_cnt;
                  n_node     <= node_cnt;
                  if (last_node) begin
                     node_cnt <= '0;
                     tree_cnt <= (tree_cnt == TW'(N_TREES - 1)) ? '0 : tree_cnt + TW'(1);
                  end else begin
                     node_cnt <= node_cnt + NW'(1);
                  end
               end
            end
            LOAD_FEAT: begin
               if (in_hs) begin
                  load_features <= 1'b1;
                  features2     <= in_data;
                  n_feature     <= feat_cnt;
                  feat_cnt      <= last_feat_word ? '0 : feat_cnt + 32'd2;
               end
            end
            WAIT: begin
               if (done_ok) begin
                  out_data  <= prediction;
                  out_valid <= 1'b1;
               end
            end
            OUTPUT: begin
               if (out_hs) begin
                  out_valid  <= 1'b0;
                  sample_cnt <= sample_cnt + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_trees_feeder.sv
// Directed bench for trees_feeder with a small ensemble (2 trees x 4 nodes, 4 features).
module tb_trees_feeder;

   localparam int NT = 2;
   localparam int NN = 4;
   localparam int NF = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cfg_start = 1'b0, cfg_load_trees = 1'b0;
   logic [31:0] cfg_n_samples = '0;
   logic        in_valid = 1'b0, in_ready;
   logic [63:0] in_data = '0;
   logic        load_trees, load_features, start, out_valid, busy, acc_done;
   logic [1:0]  n_node;
   logic [0:0]  n_tree;
   logic [63:0] tree_nodes, features2;
   logic [31:0] n_feature, out_data, prediction;
   logic        done, out_ready = 1'b1;
   logic        mdl_done = 1'b0, man_done = 1'b0;
   logic [31:0] mdl_pred = '0, man_pred = '0;

   assign done       = mdl_done | man_done;
   assign prediction = man_done ? man_pred : mdl_pred;

   always #5 clk = ~clk;

   trees_feeder #(.N_TREES(NT), .N_NODE_AND_LEAFS(NN), .N_FEATURE(NF)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_load_trees(cfg_load_trees),
      .cfg_n_samples(cfg_n_samples), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .load_trees(load_trees), .n_node(n_node), .n_tree(n_tree), .tree_nodes(tree_nodes),
      .load_features(load_features), .n_feature(n_feature), .features2(features2), .start(start),
      .prediction(prediction), .done(done), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .busy(busy), .acc_done(acc_done)
   );

   int checks = 0, failures = 0;

   typedef struct { int t; int n; logic [63:0] d; } tree_exp_t;
   typedef struct { int f; logic [63:0] d; } feat_exp_t;
   tree_exp_t   tree_q[$];
   feat_exp_t   feat_q[$];
   logic [31:0] out_q[$], pred_q[$];
   int n_tree_stb = 0, n_feat_stb = 0, n_start = 0, n_out = 0, n_acc = 0;
   int s_tree, s_feat, s_start, s_out, s_acc;
   bit model_en = 1'b1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every strobe and every output handshake is matched against queued expectations
   always @(negedge clk) begin
      tree_exp_t te;
      feat_exp_t fe;
      logic [31:0] oe;
      if (rst_n) begin
         if (load_trees) begin
            n_tree_stb++;
            check("strobe_exclusive", 64'(load_features), 64'd0);
            if (tree_q.size() == 0) check("tree_unexpected", 64'(load_trees), 64'd0);
            else begin
               te = tree_q.pop_front();
               check("n_tree", 64'(n_tree), 64'(te.t));
               check("n_node", 64'(n_node), 64'(te.n));
               check("tree_nodes", tree_nodes, te.d);
            end
         end
         if (load_features) begin
            n_feat_stb++;
            if (feat_q.size() == 0) check("feat_unexpected", 64'(load_features), 64'd0);
            else begin
               fe = feat_q.pop_front();
               check("n_feature", 64'(n_feature), 64'(fe.f));
               check("features2", features2, fe.d);
            end
         end
         if (start) begin
            n_start++;
            check("start_alone", 64'(load_trees | load_features), 64'd0);
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (out_q.size() == 0) check("out_unexpected", 64'(out_valid), 64'd0);
            else begin
               oe = out_q.pop_front();
               check("out_data", 64'(out_data), 64'(oe));
            end
         end
         if (acc_done) n_acc++;
      end
   end

   // ensemble model: answers each start one cycle later with the next queued prediction
   initial begin
      forever begin
         @(negedge clk);
         if (start && model_en && rst_n) begin
            @(posedge clk); #1;
            mdl_pred = (pred_q.size() != 0) ? pred_q.pop_front() : 32'd0;
            mdl_done = 1'b1;
            @(posedge clk); #1;
            mdl_done = 1'b0;
         end
      end
   end

   task automatic send_word(input logic [63:0] d, input bit stall);
      int cyc;
      if (stall) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = d;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!in_ready && cyc < 200);
      if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic start_job(input bit lt, input int ns);
      @(posedge clk); #1;
      cfg_start = 1'b1; cfg_load_trees = lt; cfg_n_samples = 32'(ns);
      @(posedge clk); #1;
      cfg_start = 1'b0;
   endtask

   task automatic tree_image(input logic [31:0] tag, input bit stall);
      tree_exp_t te;
      for (int i = 0; i < NT * NN; i++) begin
         te.t = i / NN; te.n = i % NN; te.d = {tag, 32'(i)};
         tree_q.push_back(te);
         send_word(te.d, stall);
      end
   endtask

   task automatic sample(input logic [31:0] tag, input bit stall);
      feat_exp_t fe;
      for (int j = 0; j < NF / 2; j++) begin
         fe.f = 2 * j; fe.d = {tag + 32'(2 * j + 1), tag + 32'(2 * j)};
         feat_q.push_back(fe);
         send_word(fe.d, stall);
      end
   endtask

   task automatic wait_acc(input int budget, output int cyc);
      cyc = 0;
      forever begin
         @(negedge clk); cyc++;
         if (acc_done || cyc >= budget) break;
      end
      check("acc_done_seen", 64'(acc_done), 64'd1);
   endtask

   task automatic snap();
      s_tree = n_tree_stb; s_feat = n_feat_stb; s_start = n_start; s_out = n_out; s_acc = n_acc;
   endtask

   task automatic deltas(input string tag, input int t, input int f, input int s, input int o);
      repeat (3) @(negedge clk);
      check({tag, "_tree_stb"}, 64'(n_tree_stb - s_tree), 64'(t));
      check({tag, "_feat_stb"}, 64'(n_feat_stb - s_feat), 64'(f));
      check({tag, "_starts"},   64'(n_start - s_start),   64'(s));
      check({tag, "_outputs"},  64'(n_out - s_out),       64'(o));
      check({tag, "_acc_done"}, 64'(n_acc - s_acc),       64'd1);
      check({tag, "_busy"},     64'(busy),                64'd0);
   endtask

   task automatic full_job(input string tag, input bit stall, input logic [31:0] p0, input logic [31:0] p1);
      int cyc;
      snap();
      pred_q.push_back(p0); out_q.push_back(p0);
      pred_q.push_back(p1); out_q.push_back(p1);
      start_job(1'b1, 2);
      tree_image(32'hA5A5_0000, stall);
      sample(32'h0000_1000, stall);
      sample(32'h0000_2000, stall);
      wait_acc(300, cyc);
      deltas(tag, 8, 4, 2, 2);
   endtask

   initial begin
      int cyc;
      #2 rst_n = 1'b0;
      #10;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_outputs", {load_trees, load_features, start, out_valid, acc_done}, 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      @(negedge clk) rst_n = 1'b1;

      full_job("full", 1'b0, 32'd3, 32'd1);
      full_job("stall", 1'b1, 32'd5, 32'hFFFF_FFFE);

      // empty job without trees: acc_done two cycles after the cfg_start pulse
      snap();
      start_job(1'b0, 0);
      wait_acc(20, cyc);
      check("empty_acc_latency", 64'(cyc), 64'd2);
      deltas("empty", 0, 0, 0, 0);

      snap();
      start_job(1'b1, 0);
      tree_image(32'h0BAD_0000, 1'b0);
      wait_acc(50, cyc);
      deltas("trees_only", 8, 0, 0, 0);

      // output backpressure: the next sample's word is offered while the result is held
      snap();
      out_ready = 1'b0;
      pred_q.push_back(32'd7); out_q.push_back(32'd7);
      pred_q.push_back(32'd9); out_q.push_back(32'd9);
      start_job(1'b0, 2);
      sample(32'h0000_3000, 1'b0);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!out_valid && cyc < 50);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0001;
      s_feat = n_feat_stb;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_hold_valid", 64'(out_valid), 64'd1);
         check("bp_hold_data", 64'(out_data), 64'd7);
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      check("bp_no_load", 64'(n_feat_stb - s_feat), 64'd0);
      s_feat = s_feat - 2;
      @(posedge clk); #1 out_ready = 1'b1;
      sample(32'h0000_4000, 1'b0);
      wait_acc(100, cyc);
      deltas("backpressure", 0, 4, 2, 2);

      // spurious done pulses in LOAD_FEAT and in the start cycle must be ignored
      snap();
      model_en = 1'b0;
      start_job(1'b0, 1);
      begin
         feat_exp_t fe;
         fe.f = 0; fe.d = 64'h0000_0051_0000_0050; feat_q.push_back(fe);
         send_word(fe.d, 1'b0);
         man_pred = 32'd99; man_done = 1'b1;
         @(posedge clk); #1 man_done = 1'b0;
         fe.f = 2; fe.d = 64'h0000_0053_0000_0052; feat_q.push_back(fe);
         send_word(fe.d, 1'b0);
      end
      @(posedge clk); #1;
      man_pred = 32'd99; man_done = 1'b1;
      @(negedge clk);
      check("spur_start_cycle", 64'(start), 64'd1);
      @(posedge clk); #1 man_done = 1'b0;
      @(negedge clk);
      check("spur_ignored", 64'(out_valid), 64'd0);
      repeat (3) @(negedge clk);
      check("spur_still_waiting", 64'(out_valid), 64'd0);
      out_q.push_back(32'd42);
      @(posedge clk); #1 man_pred = 32'd42; man_done = 1'b1;
      @(posedge clk); #1 man_done = 1'b0;
      @(negedge clk);
      check("spur_real_valid", 64'(out_valid), 64'd1);
      check("spur_real_data", 64'(out_data), 64'd42);
      wait_acc(20, cyc);
      deltas("spurious", 0, 2, 1, 1);
      model_en = 1'b1;

      // reset in LOAD_FEAT aborts the job at once
      snap();
      start_job(1'b1, 2);
      tree_image(32'h7777_0000, 1'b0);
      begin
         feat_exp_t fe;
         fe.f = 0; fe.d = 64'h1111_2222_3333_4444; feat_q.push_back(fe);
         send_word(fe.d, 1'b0);
      end
      @(posedge clk); #2;
      in_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 64'(in_ready), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_strobes", {load_trees, load_features, start, out_valid, acc_done}, 64'd0);
      check("mid_rst_tree_nodes", tree_nodes, 64'd0);
      check("mid_rst_features2", features2, 64'd0);
      check("mid_rst_idx", {n_feature, 30'd0, n_tree, n_node}, 64'd0);
      check("mid_rst_no_acc", 64'(n_acc - s_acc), 64'd0);
      in_valid = 1'b0;
      tree_q.delete(); feat_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      full_job("after_rst", 1'b0, 32'd3, 32'd1);
      check("queues_drained", 64'(tree_q.size() + feat_q.size() + out_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trees_feeder.md
Name: trees_feeder

Overview:
- Control and streaming front-end placed directly upstream of the tree-ensemble inference block.
- Takes one 64-bit input stream and, as configured, first loads every tree node word into the ensemble.
- Then, for each sample: loads that sample's feature words, pulses start, waits for done, and pushes the 32-bit prediction onto an output stream.
- Finishes with a one-cycle acc_done pulse after the last sample.

Parameters:
- N_TREES, 16, number of trees in the ensemble. Addressed by n_tree.
- N_NODE_AND_LEAFS, 256, node words per tree. Addressed by n_node.
- N_FEATURE, 32, 32-bit features per sample. Must be even, since there are two features per input word.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse that starts a job. Sampled only in IDLE.
- cfg_load_trees  in  1  sampled with cfg_start. When 1, the tree image precedes the samples on the input stream.
- cfg_n_samples  in  32  sampled with cfg_start. Number of samples in the job.
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted
- in_data  in  64  tree node word, or feature pair: [31:0] is feature k, [63:32] is feature k+1
- load_trees  out  1  tree-node write strobe
- n_node  out  $clog2(N_NODE_AND_LEAFS)  node index
- n_tree  out  $clog2(N_TREES)  tree index
- tree_nodes  out  64  node word
- load_features  out  1  feature-pair write strobe
- n_feature  out  32  even feature index
- features2  out  64  feature pair
- start  out  1  inference start pulse
- prediction  in  32  signed class index from the ensemble
- done  in  1  ensemble result-valid pulse
- out_valid  out  1  prediction valid
- out_ready  in  1  downstream accepts the prediction
- out_data  out  32  prediction
- busy  out  1  high in any state other than IDLE
- acc_done  out  1  one-cycle pulse when the job completes

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0. Reset asserted mid-job aborts the job immediately. No partial result is emitted and acc_done does not pulse.
- States:
  - IDLE
    - On cfg_start, latch cfg_load_trees and cfg_n_samples; clear sample_cnt, node_cnt, tree_cnt and feat_cnt.
    - Next state is LOAD_TREES if cfg_load_trees is 1, otherwise LOAD_FEAT.
    - If cfg_n_samples is 0 and cfg_load_trees is 0, go straight to FINISH.
  - LOAD_TREES
    - in_ready is 1.
    - Each handshake (in_valid & in_ready) registers load_trees=1, tree_nodes=in_data, n_tree=tree_cnt, n_node=node_cnt for exactly the next cycle.
    - node_cnt increments and wraps at N_NODE_AND_LEAFS-1, then tree_cnt increments.
    - After handshake number N_TREES*N_NODE_AND_LEAFS, go to LOAD_FEAT, or to FINISH if n_samples is 0.
  - LOAD_FEAT
    - in_ready is 1.
    - Each handshake registers load_features=1, features2=in_data, n_feature=feat_cnt for the next cycle; feat_cnt then increments by 2.
    - After the handshake with feat_cnt=N_FEATURE-2, clear feat_cnt and go to START.
  - START
    - Entered in the same cycle that the final load_features strobe is high.
    - Registers start=1 for exactly the following cycle, so start is never coincident with a load strobe. Go to WAIT.
  - WAIT
    - done is ignored in the cycle where start is high.
    - On the first later cycle with done=1: capture prediction into out_data, set out_valid=1, go to OUTPUT.
  - OUTPUT
    - Hold out_valid and out_data stable until out_ready.
    - On the handshake: clear out_valid and increment sample_cnt.
    - If sample_cnt+1 equals n_samples, go to FINISH; otherwise go to LOAD_FEAT.
  - FINISH
    - Drive acc_done=1 for one cycle, then return to IDLE.
- Handshake rules:
  - in_ready is 0 outside LOAD_TREES and LOAD_FEAT.
  - An in_valid that is held while in_ready is 0 is not consumed.
  - Input stalls (in_valid=0) pause the counters with no loss of data.
- Load strobes are single-cycle and occur only for accepted words. load_trees and load_features are never both high.
- cfg_start is ignored while busy=1.
- A done that arrives outside WAIT is ignored.
- Counter widths:
  - sample_cnt is 32 bits.
  - tree_cnt and node_cnt use their port widths; wrap-around at the top is the terminal condition.

Decomposition:
- Package trees_pkg holds:
  - the feeder_st_t enum {IDLE, LOAD_TREES, LOAD_FEAT, START, WAIT, OUTPUT, FINISH};
  - the localparam TREE_WORDS = N_TREES*N_NODE_AND_LEAFS;
  - the localparam FEAT_WORDS = N_FEATURE/2.
- No sub-module is needed. The output holding register stays inline.

Test Plan:
(Parameters N_TREES=2, N_NODE_AND_LEAFS=4, N_FEATURE=4 throughout.)
- Full job: cfg_load_trees=1, cfg_n_samples=2, 8 tree words then 2×2 feature words; model returns done with predictions 3 and 1 -> exactly 8 load_trees strobes with (tree,node) going (0,0)..(1,3), n_feature 0,2,0,2, two start pulses, out_data 3 then 1, then one acc_done.
- Input stalls: in_valid toggling 1/0 randomly during loads -> strobe count and indices are unchanged, with no duplicated or skipped words.
- Output backpressure: out_ready held 0 for 10 cycles after done -> out_valid stays 1 and out_data stays stable, in_ready stays 0, and the next sample's load begins only after the handshake.
- Empty job: cfg_load_trees=0, cfg_n_samples=0 -> acc_done exactly 2 cycles after cfg_start, with no strobes. cfg_load_trees=1, cfg_n_samples=0 -> 8 tree strobes, then acc_done.
- Spurious done: done pulsed in LOAD_FEAT and in the start cycle -> ignored, and out_valid rises only on the later done.
- Reset mid-job: rst_n low during LOAD_FEAT -> all outputs 0 immediately. A subsequent full job behaves identically to the full-job scenario above.
